// File: rtl/sram_dual_port_arbiter.sv
// Dual-port (fetch + load/store) controller for BaseRAM/ExtRAM with one access engine per bank.
// Wait states are set by WAIT_CYCLES; completion is signalled by one-cycle ready pulses.

module sram_bank_engine #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic               req_owner_i,   // 1 = data port, 0 = fetch port
    input  logic               req_we_i,
    input  logic [3:0]         req_sel_i,
    input  logic [SRAM_AW-1:0] req_addr_i,
    input  logic [31:0]        req_wdata_i,
    output logic               idle_o,
    output logic               done_o,
    output logic               owner_o,
    output logic               sample_o,
    output logic [1:0]         state_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [3:0]         be_n_o,
    output logic               ce_n_o,
    output logic               oe_n_o,
    output logic               we_n_o,
    output logic               dq_oe_o,
    output logic [31:0]        dq_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [3:0]         be_n_q, be_n_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [31:0]        wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_n_q  <= 4'h0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_n_q  <= be_n_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_n_d   = be_n_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        dq_oe_d  = dq_oe_q;
        wdata_d  = wdata_q;
        sample_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_ACCESS;
                    owner_d = req_owner_i;
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_n_d  = req_we_i ? ~req_sel_i : 4'h0;
                    ce_n_d  = 1'b0;
                    oe_n_d  = req_we_i;
                    we_n_d  = ~req_we_i;
                    dq_oe_d = req_we_i;
                    cnt_d   = CNT_INIT;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    sample_o = ~we_q;
                    ce_n_d   = 1'b1;
                    oe_n_d   = 1'b1;
                    we_n_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // Write data stays on the bus through this cycle for hold time after we_n rises.
                dq_oe_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign idle_o      = (state_q == S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign owner_o     = owner_q;
    assign state_o     = state_q;
    assign sram_addr_o = addr_q;
    assign be_n_o      = be_n_q;
    assign ce_n_o      = ce_n_q;
    assign oe_n_o      = oe_n_q;
    assign we_n_o      = we_n_q;
    assign dq_oe_o     = dq_oe_q;
    assign dq_o        = wdata_q;
endmodule

module sram_dual_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int BANK_BIT    = 22,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_ce_i,
    input  logic [31:0]        inst_addr_i,
    output logic [31:0]        inst_data_o,
    output logic               inst_ready_o,
    input  logic               data_ce_i,
    input  logic               data_we_i,
    input  logic [3:0]         data_sel_i,
    input  logic [31:0]        data_addr_i,
    input  logic [31:0]        data_wdata_i,
    output logic [31:0]        data_rdata_o,
    output logic               data_ready_o,
    output logic               stall_o,
    inout  wire  [31:0]        base_ram_data,
    output logic [SRAM_AW-1:0] base_ram_addr,
    output logic [3:0]         base_ram_be_n,
    output logic               base_ram_ce_n,
    output logic               base_ram_oe_n,
    output logic               base_ram_we_n,
    inout  wire  [31:0]        ext_ram_data,
    output logic [SRAM_AW-1:0] ext_ram_addr,
    output logic [3:0]         ext_ram_be_n,
    output logic               ext_ram_ce_n,
    output logic               ext_ram_oe_n,
    output logic               ext_ram_we_n
);
    logic inst_to_ext, data_to_ext, inst_busy, data_busy;
    logic base_idle, base_done, base_owner, base_sample, base_dq_oe;
    logic ext_idle, ext_done, ext_owner, ext_sample, ext_dq_oe;
    logic base_take_data, base_take_inst, ext_take_data, ext_take_inst;
    logic [31:0] base_dq, ext_dq;
    logic [1:0]  dbg_base_state, dbg_ext_state;
    logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic [SRAM_AW-1:0] inst_word, data_word;

    assign inst_to_ext = inst_addr_i[BANK_BIT];
    assign data_to_ext = data_addr_i[BANK_BIT];
    assign inst_word   = inst_addr_i[SRAM_AW+1:2];
    assign data_word   = data_addr_i[SRAM_AW+1:2];

    // A port already in flight on an engine must not be granted again until its ready pulse passes.
    assign inst_busy = (~base_idle & ~base_owner) | (~ext_idle & ~ext_owner);
    assign data_busy = (~base_idle &  base_owner) | (~ext_idle &  ext_owner);

    assign base_take_data = data_ce_i & ~data_to_ext & ~data_busy;
    assign base_take_inst = inst_ce_i & ~inst_to_ext & ~inst_busy & ~base_take_data;
    assign ext_take_data  = data_ce_i &  data_to_ext & ~data_busy;
    assign ext_take_inst  = inst_ce_i &  inst_to_ext & ~inst_busy & ~ext_take_data;

    sram_bank_engine #(.WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) u_base (
        .clk(clk), .rst(rst),
        .req_i(base_take_data | base_take_inst), .req_owner_i(base_take_data),
        .req_we_i(base_take_data & data_we_i), .req_sel_i(data_sel_i),
        .req_addr_i(base_take_data ? data_word : inst_word), .req_wdata_i(data_wdata_i),
        .idle_o(base_idle), .done_o(base_done), .owner_o(base_owner), .sample_o(base_sample),
        .state_o(dbg_base_state), .sram_addr_o(base_ram_addr), .be_n_o(base_ram_be_n),
        .ce_n_o(base_ram_ce_n), .oe_n_o(base_ram_oe_n), .we_n_o(base_ram_we_n),
        .dq_oe_o(base_dq_oe), .dq_o(base_dq)
    );

    sram_bank_engine #(.WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) u_ext (
        .clk(clk), .rst(rst),
        .req_i(ext_take_data | ext_take_inst), .req_owner_i(ext_take_data),
        .req_we_i(ext_take_data & data_we_i), .req_sel_i(data_sel_i),
        .req_addr_i(ext_take_data ? data_word : inst_word), .req_wdata_i(data_wdata_i),
        .idle_o(ext_idle), .done_o(ext_done), .owner_o(ext_owner), .sample_o(ext_sample),
        .state_o(dbg_ext_state), .sram_addr_o(ext_ram_addr), .be_n_o(ext_ram_be_n),
        .ce_n_o(ext_ram_ce_n), .oe_n_o(ext_ram_oe_n), .we_n_o(ext_ram_we_n),
        .dq_oe_o(ext_dq_oe), .dq_o(ext_dq)
    );

    assign base_ram_data = base_dq_oe ? base_dq : 32'bz;
    assign ext_ram_data  = ext_dq_oe  ? ext_dq  : 32'bz;

    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (base_sample & ~base_owner) inst_rdata_d = base_ram_data;
        if (ext_sample  & ~ext_owner)  inst_rdata_d = ext_ram_data;
        if (base_sample &  base_owner) data_rdata_d = base_ram_data;
        if (ext_sample  &  ext_owner)  data_rdata_d = ext_ram_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign inst_data_o  = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign inst_ready_o = ~rst & ((base_done & ~base_owner) | (ext_done & ~ext_owner));
    assign data_ready_o = ~rst & ((base_done &  base_owner) | (ext_done &  ext_owner));
    assign stall_o      = ~rst & ((inst_ce_i & ~inst_ready_o) | (data_ce_i & ~data_ready_o));

    logic unused_sink;
    assign unused_sink = ^{inst_addr_i, data_addr_i, dbg_base_state, dbg_ext_state};
endmodule
